// File: rtl/ccff_stream_loader.sv
// Serializes a valid/ready word stream MSB-first into a CCFF configuration chain.
// Optional ccff_tail check against the first shifted bit: define CCFF_TAIL_CHECK_EN.
module ccff_stream_loader #(
  parameter int  CHAIN_LEN = 62,
  parameter int  WORD_W    = 8,
  localparam int CNT_W     = $clog2(CHAIN_LEN + 1)
) (
  input  logic              prog_clk,
  input  logic              pReset,
  input  logic              start,
  input  logic              abort,
  input  logic [WORD_W-1:0] s_data,
  input  logic              s_valid,
  output logic              s_ready,
  output logic              ccff_head,
  output logic              shift_en,
  input  logic              ccff_tail,
  output logic              busy,
  output logic              done,
  output logic              err
);

  localparam int WC_W = (WORD_W > 1) ? $clog2(WORD_W) : 1;
  localparam logic [CNT_W-1:0] LAST_BIT  = CNT_W'(CHAIN_LEN - 1);
  localparam logic [WC_W-1:0]  LAST_WBIT = WC_W'(WORD_W - 1);

  typedef enum logic [1:0] {
    IDLE,
    WAIT_WORD,
    SHIFT,
    FINISH
  } state_t;

  state_t            state;
  logic [CNT_W-1:0]  bit_cnt;
  logic [WC_W-1:0]   wcnt;
  logic [WORD_W-1:0] shreg;

  // abort outranks every transition, including a start seen in IDLE
  always_ff @(posedge prog_clk or posedge pReset) begin
    if (pReset) begin
      state   <= IDLE;
      bit_cnt <= '0;
      wcnt    <= '0;
      shreg   <= '0;
    end else if (abort) begin
      state <= IDLE;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            state   <= WAIT_WORD;
            bit_cnt <= '0;
          end
        end
        WAIT_WORD: begin
          if (s_valid) begin
            shreg <= s_data;
            wcnt  <= '0;
            state <= SHIFT;
          end
        end
        SHIFT: begin
          shreg   <= shreg << 1;
          bit_cnt <= (bit_cnt == LAST_BIT) ? bit_cnt : bit_cnt + CNT_W'(1);
          wcnt    <= (wcnt == LAST_WBIT) ? wcnt : wcnt + WC_W'(1);
          // chain length wins over word exhaustion; leftover low bits are dropped
          if (bit_cnt == LAST_BIT) begin
            state <= FINISH;
          end else if (wcnt == LAST_WBIT) begin
            state <= WAIT_WORD;
          end
        end
        FINISH: begin
          state <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

  assign ccff_head = shreg[WORD_W-1];
  assign shift_en  = (state == SHIFT);
  assign s_ready   = (state == WAIT_WORD);
  assign busy      = (state != IDLE);
  assign done      = (state == FINISH);

`ifdef CCFF_TAIL_CHECK_EN
  logic first_bit;
  logic err_q;

  // After CHAIN_LEN shifts the first bit of the load must appear at the tail
  always_ff @(posedge prog_clk or posedge pReset) begin
    if (pReset) begin
      first_bit <= 1'b0;
      err_q     <= 1'b0;
    end else if (!abort) begin
      if (state == IDLE && start) begin
        err_q <= 1'b0;
      end
      if (state == SHIFT && bit_cnt == '0) begin
        first_bit <= shreg[WORD_W-1];
      end
      if (state == FINISH && ccff_tail != first_bit) begin
        err_q <= 1'b1;
      end
    end
  end

  assign err = err_q;
`else
  logic unused_tail;
  assign unused_tail = ccff_tail;
  assign err         = 1'b0;
`endif

endmodule
